// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine for the 1bpp 640x480 framebuffer, programmed over Avalon-MM.
// Optional pixel-granularity read-modify-write edges are enabled by defining FB_RMW_EN.
module fb_rect_fill #(
  parameter int unsigned WORDS_PER_ROW = 20,
  parameter int unsigned ROWS          = 480,
  parameter int unsigned FB_AW         = 15
) (
  input  logic             clk50,
  input  logic             reset,
  input  logic             chipselect,
  input  logic             write,
  input  logic             read,
  input  logic [2:0]       address,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [FB_AW-1:0] fb_address,
  output logic [31:0]      fb_writedata,
  output logic             fb_write,
  output logic [FB_AW-1:0] fb_rdaddress,
  input  logic [31:0]      fb_readdata,
  output logic             busy,
  output logic             done_irq
);

  localparam int unsigned XMAX   = WORDS_PER_ROW * 32;
  localparam logic [31:0] ALL1   = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_FILL, S_FILL_RD, S_FILL_WAIT, S_FILL_WR, S_DONE
  } state_t;

  state_t state_q;

  // host-visible copies
  logic [9:0]  x0_q, w_q;
  logic [8:0]  y0_q, h_q;
  logic [31:0] pat_q;
  logic        error_q;

  // shadows frozen at start so host writes never disturb a running fill
  logic [9:0]  x0_s, w_s;
  logic [8:0]  y0_s, h_s;
  logic [31:0] pat_s;

  // fill walker
  logic [4:0]       col_q;
  logic [FB_AW-1:0] base_q;
  logic [8:0]       rows_q;

  logic [9:0]       x0_e, w_e;
  logic [10:0]      x_end, y_end, x_last;
  logic             bad_geom;
  logic [4:0]       xs, xe;
  logic [FB_AW-1:0] base0;
  logic             row_end, last_word;
  logic [4:0]       d_col;
  logic [FB_AW-1:0] d_base, d_addr;
  logic             start_req;
  logic             unused_bits;

`ifdef FB_RMW_EN
  logic [31:0] d_mask, mask_q;
  logic        d_partial;

  assign x0_e = x0_s;
  assign w_e  = w_s;
  assign unused_bits = ^{read, x_last[10]};
`else
  // word granularity: low five bits of X0 and W are ignored
  assign x0_e = {x0_s[9:5], 5'd0};
  assign w_e  = {w_s[9:5], 5'd0};
  assign fb_rdaddress = '0;
  assign unused_bits = ^{read, x0_s[4:0], w_s[4:0], x_last[10], x_last[4:0], fb_readdata};
`endif

  // geometry derived from the shadows; stable for the whole fill
  always_comb begin
    x_end    = {1'b0, x0_e} + {1'b0, w_e};
    y_end    = {2'b0, y0_s} + {2'b0, h_s};
    x_last   = x_end - 11'd1;
    bad_geom = (w_e == 10'd0) || (h_s == 9'd0) ||
               (x_end > 11'(XMAX)) || (y_end > 11'(ROWS));
    xs       = x0_e[9:5];
    xe       = x_last[9:5];
    base0    = FB_AW'({y0_s, 4'b0000}) + FB_AW'({y0_s, 2'b00});
  end

  // next word to issue: first word from CHECK, otherwise successor of col_q
  always_comb begin
    row_end   = (col_q == xe);
    last_word = row_end && (rows_q == 9'd1);
    d_col     = col_q + 5'd1;
    d_base    = base_q;
    if (state_q == S_CHECK) begin
      d_col  = xs;
      d_base = base0;
    end else if (row_end) begin
      d_col  = xs;
      d_base = base_q + FB_AW'(WORDS_PER_ROW);
    end
    d_addr = d_base + FB_AW'(d_col);
`ifdef FB_RMW_EN
    d_mask = ALL1;
    if (d_col == xs) d_mask = d_mask & (ALL1 << x0_e[4:0]);
    if (d_col == xe) d_mask = d_mask & (ALL1 >> (5'd31 - x_last[4:0]));
    d_partial = (d_mask != ALL1);
`endif
  end

  assign start_req = chipselect && write && (address == 3'd5) && writedata[0];

  // register file readback, zero wait
  always_comb begin
    readdata = 32'd0;
    case (address)
      3'd0: readdata = {22'd0, x0_q};
      3'd1: readdata = {23'd0, y0_q};
      3'd2: readdata = {22'd0, w_q};
      3'd3: readdata = {23'd0, h_q};
      3'd4: readdata = pat_q;
      3'd5: readdata = {30'd0, error_q, busy};
      default: readdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      x0_q         <= '0;
      y0_q         <= '0;
      w_q          <= '0;
      h_q          <= '0;
      pat_q        <= '0;
      error_q      <= 1'b0;
      x0_s         <= '0;
      y0_s         <= '0;
      w_s          <= '0;
      h_s          <= '0;
      pat_s        <= '0;
      col_q        <= '0;
      base_q       <= '0;
      rows_q       <= '0;
      fb_address   <= '0;
      fb_writedata <= '0;
      fb_write     <= 1'b0;
      busy         <= 1'b0;
      done_irq     <= 1'b0;
`ifdef FB_RMW_EN
      fb_rdaddress <= '0;
      mask_q       <= '0;
`endif
    end else begin
      done_irq <= 1'b0;
      fb_write <= 1'b0;

      if (chipselect && write) begin
        case (address)
          3'd0: x0_q  <= writedata[9:0];
          3'd1: y0_q  <= writedata[8:0];
          3'd2: w_q   <= writedata[9:0];
          3'd3: h_q   <= writedata[8:0];
          3'd4: pat_q <= writedata;
          default: ;
        endcase
      end

      case (state_q)
        S_IDLE: begin
          if (start_req) begin
            x0_s    <= x0_q;
            y0_s    <= y0_q;
            w_s     <= w_q;
            h_s     <= h_q;
            pat_s   <= pat_q;
            error_q <= 1'b0;
            busy    <= 1'b1;
            state_q <= S_CHECK;
          end
        end

        // CHECK issues the first word; FILL/FILL_WR retire one and issue the next
        S_CHECK, S_FILL, S_FILL_WR: begin
          if (state_q == S_CHECK && bad_geom) begin
            error_q  <= 1'b1;
            done_irq <= 1'b1;
            state_q  <= S_DONE;
          end else if (state_q != S_CHECK && last_word) begin
            done_irq <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            col_q      <= d_col;
            base_q     <= d_base;
            fb_address <= d_addr;
            if (state_q == S_CHECK) rows_q <= h_s;
            else if (row_end)       rows_q <= rows_q - 9'd1;
`ifdef FB_RMW_EN
            if (d_partial) begin
              fb_rdaddress <= d_addr;
              mask_q       <= d_mask;
              state_q      <= S_FILL_RD;
            end else
`endif
            begin
              fb_write     <= 1'b1;
              fb_writedata <= pat_s;
              state_q      <= S_FILL;
            end
          end
        end

`ifdef FB_RMW_EN
        S_FILL_RD: state_q <= S_FILL_WAIT;

        // old word arrives this cycle; merge pattern under the edge mask
        S_FILL_WAIT: begin
          fb_writedata <= (fb_readdata & ~mask_q) | (pat_s & mask_q);
          fb_write     <= 1'b1;
          state_q      <= S_FILL_WR;
        end
`endif

        S_DONE: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Randomized bench for fb_rect_fill: a pixel-level rectangle model predicts the
// framebuffer image, write-address order and completion latency.
module tb_fb_rect_fill;

  logic        clk50 = 1'b0;
  logic        reset;
  logic        chipselect, write, read;
  logic [2:0]  address;
  logic [31:0] writedata, readdata;
  logic [14:0] fb_address, fb_rdaddress;
  logic [31:0] fb_writedata, fb_readdata;
  logic        fb_write, busy, done_irq;

  fb_rect_fill dut (
    .clk50(clk50), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .fb_address(fb_address), .fb_writedata(fb_writedata), .fb_write(fb_write),
    .fb_rdaddress(fb_rdaddress), .fb_readdata(fb_readdata),
    .busy(busy), .done_irq(done_irq)
  );

  always #10 clk50 = ~clk50;

  logic [31:0] ram     [0:9599];
  logic [31:0] exp_mem [0:9599];
  int wr_q[$];
  int exp_q[$];
  int done_cnt = 0;
  int rd_bad = 0;
  int oob = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // framebuffer RAM with 1-cycle read latency plus write/irq monitors
  always @(posedge clk50) begin
    if (fb_write) begin
      if (int'(fb_address) < 9600) ram[fb_address] <= fb_writedata;
      else oob++;
      wr_q.push_back(int'(fb_address));
    end
    fb_readdata <= (int'(fb_rdaddress) < 9600) ? ram[fb_rdaddress] : 32'd0;
    if (done_irq) done_cnt++;
`ifndef FB_RMW_EN
    if (fb_rdaddress != 15'd0) rd_bad++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk50);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    #1 d = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  // pixel-level model: paints the rectangle and lists touched words in row-major order
  task automatic model_fill(input int x0, input int y0, input int w, input int h,
                            input logic [31:0] pat, output bit err, output int nw, output int extra);
    int ex0, ew, a, cov, px;
    logic [31:0] v;
    ex0 = x0; ew = w;
`ifndef FB_RMW_EN
    ex0 = ex0 - ex0 % 32;
    ew  = ew - ew % 32;
`endif
    err = (ew == 0) || (h == 0) || (ex0 + ew > 640) || (y0 + h > 480);
    nw = 0; extra = 0;
    exp_q.delete();
    if (!err) begin
      for (int y = y0; y < y0 + h; y++) begin
        for (int wd = ex0 / 32; wd <= (ex0 + ew - 1) / 32; wd++) begin
          a = y * 20 + wd; v = exp_mem[a]; cov = 0;
          for (int b = 0; b < 32; b++) begin
            px = wd * 32 + b;
            if (px >= ex0 && px < ex0 + ew) begin v[b] = pat[b]; cov++; end
          end
          exp_mem[a] = v;
          exp_q.push_back(a);
          nw++;
          if (cov != 32) extra += 2;
        end
      end
    end
  endtask

  task automatic run_fill(input string nm, input int x0, input int y0, input int w, input int h,
                          input logic [31:0] pat, input int inj);
    bit err;
    int nw, extra, idx0, dn0, t, budget, busy_bad, bad, diff, n;
    logic [31:0] d;
    model_fill(x0, y0, w, h, pat, err, nw, extra);
    reg_wr(3'd0, 32'(x0)); reg_wr(3'd1, 32'(y0)); reg_wr(3'd2, 32'(w));
    reg_wr(3'd3, 32'(h));  reg_wr(3'd4, pat);
    idx0 = wr_q.size(); dn0 = done_cnt;
    reg_wr(3'd5, 32'h1);
    t = 1; budget = 3 * nw + 50; busy_bad = 0;
    while (done_irq !== 1'b1 && t < budget) begin
      if (busy !== 1'b1) busy_bad++;
      if (inj > 0) begin
        if (t == inj) begin
          chipselect = 1'b1; write = 1'b1; address = 3'd5; writedata = 32'h1;
        end else if (t == inj + 1) begin
          address = 3'd0; writedata = 32'hFFFF_FD55;
        end else if (t == inj + 2) begin
          chipselect = 1'b0; write = 1'b0;
        end else if (t == inj + 3) begin
          reg_rd(3'd5, d); chk({nm, ":status_busy"}, d, 32'h1);
        end
      end
      @(negedge clk50); t++;
    end
    chipselect = 1'b0; write = 1'b0;
    chk({nm, ":latency"}, 32'(t), 32'(2 + nw + extra));
    chk({nm, ":busy_during"}, 32'(busy_bad), 32'd0);
    @(negedge clk50);
    chk({nm, ":idle_after"}, {29'd0, busy, done_irq, fb_write}, 32'd0);
    reg_rd(3'd5, d);
    chk({nm, ":status"}, d, {30'd0, err, 1'b0});
    chk({nm, ":done_pulses"}, 32'(done_cnt - dn0), 32'd1);
    chk({nm, ":wr_count"}, 32'(wr_q.size() - idx0), 32'(exp_q.size()));
    bad = 0;
    n = (wr_q.size() - idx0 < exp_q.size()) ? wr_q.size() - idx0 : exp_q.size();
    for (int i = 0; i < n; i++) if (wr_q[idx0 + i] != exp_q[i]) bad++;
    chk({nm, ":addr_seq"}, 32'(bad), 32'd0);
    diff = 0;
    for (int i = 0; i < 9600; i++) if (ram[i] !== exp_mem[i]) diff++;
    chk({nm, ":mem_image"}, 32'(diff), 32'd0);
    if (inj > 0) begin
      reg_rd(3'd0, d);
      chk({nm, ":x0_host"}, d, 32'h155);
    end
  endtask

  task automatic reset_mid_fill();
    int idx0, dn0, t;
    logic [31:0] d;
    reg_wr(3'd0, 32'd0); reg_wr(3'd1, 32'd0); reg_wr(3'd2, 32'd640);
    reg_wr(3'd3, 32'd480); reg_wr(3'd4, 32'hFFFF_FFFF);
    idx0 = wr_q.size(); dn0 = done_cnt;
    reg_wr(3'd5, 32'h1);
    t = 0;
    while (wr_q.size() - idx0 < 100 && t < 500) begin @(negedge clk50); t++; end
    chk("rst:reached_word100", 32'(t < 500), 32'd1);
    #3 reset = 1'b1;
    #1 chk("rst:outputs_now", {29'd0, fb_write, busy, done_irq}, 32'd0);
    chk("rst:fb_address", {17'd0, fb_address}, 32'd0);
    reg_rd(3'd5, d); chk("rst:status", d, 32'd0);
    reg_rd(3'd0, d); chk("rst:x0_cleared", d, 32'd0);
    @(negedge clk50); reset = 1'b0;
    repeat (3) @(negedge clk50);
    chk("rst:no_done", 32'(done_cnt - dn0), 32'd0);
  endtask

  initial begin
    int x0, y0, w, h, sel;
    logic [31:0] d;
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = 3'd0; writedata = 32'd0;
    for (int i = 0; i < 9600; i++) exp_mem[i] = 32'd0;
    #5;
    chk("reset:outputs", {29'd0, fb_write, busy, done_irq}, 32'd0);
    reg_rd(3'd5, d); chk("reset:status", d, 32'd0);
    repeat (2) @(negedge clk50);
    reset = 1'b0;
    @(negedge clk50);

    run_fill("full", 0, 0, 640, 480, 32'hFFFF_FFFF, 0);
    reset_mid_fill();
    run_fill("after_rst", 96, 200, 64, 3, 32'h1234_5678, 0);
`ifdef FB_RMW_EN
    run_fill("rmw_edge", 5, 0, 10, 1, 32'h0, 0);
    chk("rmw_edge:word0", ram[0], 32'hFFFF_801F);
`endif
    run_fill("small", 64, 10, 96, 2, 32'hA5A5_A5A5, 0);
    run_fill("err_x", 608, 0, 64, 1, 32'h5555_5555, 0);
    run_fill("err_h0", 0, 0, 64, 0, 32'h5555_5555, 0);
    run_fill("corner", 608, 479, 32, 1, 32'hC0DE_0001, 0);
    run_fill("busy_rules", 32, 100, 320, 20, $urandom, 50);

    for (int k = 0; k < 16; k++) begin
      x0 = $urandom_range(0, 639);
      y0 = $urandom_range(0, 479);
      sel = $urandom_range(0, 5);
      if (sel == 0) begin
        w = $urandom_range(0, 1023);
        h = $urandom_range(0, 31);
      end else begin
        w = $urandom_range(1, 640 - x0);
        h = $urandom_range(1, (480 - y0 < 24) ? 480 - y0 : 24);
      end
      run_fill($sformatf("rand%0d", k), x0, y0, w, h, $urandom, 0);
    end

    reg_rd(3'd6, d); chk("unmapped_read", d, 32'd0);
    chk("fb_addr_in_range", 32'(oob), 32'd0);
`ifndef FB_RMW_EN
    chk("rdaddr_tied", 32'(rd_bad), 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_600_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
